// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with fixed-latency result commit
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_md,
   output logic [31:0] out_data,
   output logic        start,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi, pend_lo;
   logic [63:0]   prod_s, prod_u, res;
   logic [31:0]   abs_a, abs_b, mq, mr, sq, sr, uq, ur;
   assign busy  = cnt != '0;
   assign start = en && op >= 4'd1 && op <= 4'd4 && !busy;
   assign stall = d_md && (start || busy);
   assign out_data = !en ? 32'd0 : op == 4'd5 ? hi : op == 4'd6 ? lo : 32'd0;
   always_comb begin
      prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
      prod_u = {32'd0, src_a} * {32'd0, src_b};
      abs_a  = src_a[31] ? -src_a : src_a;
      abs_b  = src_b[31] ? -src_b : src_b;
      mq     = src_b == 32'd0 ? 32'd0 : abs_a / abs_b;
      mr     = src_b == 32'd0 ? 32'd0 : abs_a % abs_b;
      sq     = (src_a[31] ^ src_b[31]) ? -mq : mq;
      sr     = src_a[31] ? -mr : mr;
      uq     = src_b == 32'd0 ? 32'd0 : src_a / src_b;
      ur     = src_b == 32'd0 ? 32'd0 : src_a % src_b;
      res    = op == 4'd1 ? prod_s :
               op == 4'd2 ? prod_u :
               src_b == 32'd0 ? {src_a, 32'hFFFF_FFFF} :
               op == 4'd3 ? {sr, sq} : {ur, uq};
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else if (start) begin
         {pend_hi, pend_lo} <= res;
         cnt <= op <= 4'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (busy) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) {hi, lo} <= {pend_hi, pend_lo};
      end else if (en && op == 4'd7) begin
         hi <= src_a;
      end else if (en && op == 4'd8) begin
         lo <= src_a;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        d_md = 1'b0;
   logic [31:0] out_data, hi, lo;
   logic        start, busy, stall;
   int n_assert = 0;
   int n_fail = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .src_a(src_a), .src_b(src_b),
      .d_md(d_md), .out_data(out_data), .start(start), .busy(busy), .stall(stall),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sp;
      longint unsigned up;
      int q, r;
      if (o == 4'd1) begin
         sp = longint'(int'(a)) * longint'(int'(b));
         return sp;
      end
      if (o == 4'd2) begin
         up = longint'({32'd0, a}) * longint'({32'd0, b});
         return up;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (o == 4'd3) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
         q = int'(a) / int'(b);
         r = int'(a) % int'(b);
         return {r, q};
      end
      return {a % b, a / b};
   endfunction

   task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit mt);
      logic [63:0] r;
      int n;
      r = model(o, a, b);
      n = (o <= 4'd2) ? 5 : 10;
      en = 1'b1; op = o; src_a = a; src_b = b; d_md = 1'b1;
      #1;
      chk("start_issue", start, 1);
      chk("stall_issue", stall, 1);
      chk("busy_issue", busy, 0);
      next();
      for (int i = 0; i < n; i++) begin
         op = (mt && i == 0) ? 4'd7 : 4'd5;
         src_a = 32'hA5A5_0000 ^ i;
         #1;
         chk("busy_run", busy, 1);
         chk("start_run", start, 0);
         chk("stall_run", stall, 1);
         chk("mfhi_busy", out_data, op == 4'd5 ? m_hi : 32'd0);
         chk("hi_hold", hi, m_hi);
         next();
      end
      m_hi = r[63:32];
      m_lo = r[31:0];
      op = 4'd5;
      #1;
      chk("busy_done", busy, 0);
      chk("stall_done", stall, 0);
      chk("mfhi_done", out_data, m_hi);
      op = 4'd6;
      #1;
      chk("mflo_done", out_data, m_lo);
      chk("hi_done", hi, m_hi);
      chk("lo_done", lo, m_lo);
      en = 1'b0; d_md = 1'b0;
      next();
   endtask

   initial begin
      logic [3:0] ro;
      logic [31:0] ra, rb;
      #2;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      next();
      en = 1'b1; op = 4'd7; src_a = 32'h1234_5678;
      next();
      m_hi = 32'h1234_5678;
      op = 4'd5; #1;
      chk("mthi_mfhi", out_data, m_hi);
      op = 4'd6; #1;
      chk("mthi_mflo", out_data, m_lo);
      en = 1'b0; op = 4'd8; src_a = 32'hDEAD_BEEF;
      next();
      chk("mtlo_en0", lo, m_lo);
      en = 1'b1; op = 4'd5; #1;
      en = 1'b0; #1;
      chk("out_en0", out_data, 0);
      en = 1'b1; op = 4'd8; src_a = 32'h0000_CAFE;
      next();
      m_lo = 32'h0000_CAFE;
      chk("mtlo_en1", lo, m_lo);
      op = 4'd9; #1;
      chk("out_op9", out_data, 0);
      en = 1'b0;
      run(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      chk("mult_hi", m_hi, 32'hFFFF_FFFF);
      run(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      chk("multu_hi", m_hi, 32'h0000_0001);
      run(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      run(4'd4, 32'd7, 32'd2, 1'b1);
      run(4'd3, 32'd5, 32'd0, 1'b0);
      run(4'd4, 32'd9, 32'd0, 1'b0);
      run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("ovf_lo", lo, 32'h8000_0000);
      for (int k = 0; k < 30; k++) begin
         ro = 4'($urandom_range(1, 4));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
         if (ra[0] && rb[0]) rb = -rb;
         run(ro, ra, rb, k[0]);
      end
      en = 1'b1; op = 4'd1; src_a = 32'h0001_0000; src_b = 32'h0003_0000; d_md = 1'b0;
      next();
      en = 1'b0;
      next();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      chk("arst_busy", busy, 0);
      en = 1'b1; op = 4'd5; #1;
      chk("arst_mfhi", out_data, 0);
      en = 1'b0;
      next();
      next();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) next();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_hi", hi, 0);
      chk("post_rst_lo", lo, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
